// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters. The lookup is combinational from the table.
// Training updates the table, and a mispredict raises a registered one-cycle redirect.
module branch_predictor #(
  parameter int unsigned IDX_BITS = 4
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_fetch_pc,
  output logic        o_pred_taken,
  output logic [31:0] o_pred_target,
  input  logic        i_upd_valid,
  input  logic [31:0] i_upd_pc,
  input  logic        i_upd_is_branch,
  input  logic [31:0] i_upd_next_pc,
  input  logic        i_upd_pred_taken,
  input  logic [31:0] i_upd_pred_target,
  input  logic        i_flush,
  output logic        o_redirect_valid,
  output logic [31:0] o_redirect_pc
);
  localparam int unsigned ENTRIES = 1 << IDX_BITS;
  localparam int unsigned TAG_W   = 32 - IDX_BITS - 2;

  logic              r_valid  [ENTRIES];
  logic [TAG_W-1:0]  r_tag    [ENTRIES];
  logic [31:0]       r_target [ENTRIES];
  logic [1:0]        r_ctr    [ENTRIES];
  logic              r_redirect_valid;
  logic [31:0]       r_redirect_pc;

  logic [IDX_BITS-1:0] w_f_idx, w_u_idx;
  logic [TAG_W-1:0]    w_f_tag, w_u_tag;
  logic                w_f_hit, w_u_hit;
  logic [31:0]         w_u_pc_plus8;
  logic                w_taken;
  logic                w_mispred;
  logic [31:0]         w_redirect_pc;

  assign w_f_idx      = i_fetch_pc[IDX_BITS+1:2];
  assign w_f_tag      = i_fetch_pc[31:IDX_BITS+2];
  assign w_u_idx      = i_upd_pc[IDX_BITS+1:2];
  assign w_u_tag      = i_upd_pc[31:IDX_BITS+2];
  assign w_u_pc_plus8 = i_upd_pc + 32'd8;

  always_comb begin
    w_f_hit       = r_valid[w_f_idx] && (r_tag[w_f_idx] == w_f_tag);
    o_pred_taken  = w_f_hit && r_ctr[w_f_idx][1];
    o_pred_target = o_pred_taken ? r_target[w_f_idx] : '0;
  end

  // A non-branch that fetch predicted taken must resume sequentially, past the delay slot
  always_comb begin
    w_u_hit       = r_valid[w_u_idx] && (r_tag[w_u_idx] == w_u_tag);
    w_taken       = i_upd_is_branch && (i_upd_next_pc != w_u_pc_plus8);
    w_mispred     = 1'b0;
    w_redirect_pc = '0;
    if (i_upd_valid) begin
      if (i_upd_is_branch) begin
        if ((i_upd_pred_taken != w_taken) ||
            (w_taken && (i_upd_pred_target != i_upd_next_pc))) begin
          w_mispred     = 1'b1;
          w_redirect_pc = i_upd_next_pc;
        end
      end else if (i_upd_pred_taken) begin
        w_mispred     = 1'b1;
        w_redirect_pc = w_u_pc_plus8;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i]  <= 1'b0;
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (i_flush) begin
      for (int unsigned i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
      end
    end else if (i_upd_valid) begin
      if (w_u_hit) begin
        if (!i_upd_is_branch) begin
          r_valid[w_u_idx] <= 1'b0;
        end else if (w_taken) begin
          if (r_ctr[w_u_idx] != 2'd3) r_ctr[w_u_idx] <= r_ctr[w_u_idx] + 2'd1;
          r_target[w_u_idx] <= i_upd_next_pc;
        end else begin
          if (r_ctr[w_u_idx] != 2'd0) r_ctr[w_u_idx] <= r_ctr[w_u_idx] - 2'd1;
        end
      end else if (w_taken) begin
        r_valid[w_u_idx]  <= 1'b1;
        r_tag[w_u_idx]    <= w_u_tag;
        r_target[w_u_idx] <= i_upd_next_pc;
        r_ctr[w_u_idx]    <= 2'd2;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_redirect_valid <= 1'b0;
      r_redirect_pc    <= '0;
    end else begin
      r_redirect_valid <= w_mispred;
      r_redirect_pc    <= w_redirect_pc;
    end
  end

  assign o_redirect_valid = r_redirect_valid;
  assign o_redirect_pc    = r_redirect_pc;
endmodule
